quan_frame_ctrl: RTL and testbench
==================================

QUAN_FRAME_CTRL -- requirements
Module: quan_frame_ctrl

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 256: samples per frame (2..511).
REQ-002 SHALL have parameter QSHIFT, default 11: quantizer right-shift amount (1..12).
REQ-003 SHALL have port clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  frame request, single-cycle pulse.
REQ-006 SHALL have port busy  output  1  frame in progress.
REQ-007 SHALL have port intr  output  1  frame-done pulse.
REQ-008 SHALL have port rd_en  output  1  source memory read enable.
REQ-009 SHALL have port addr_src  output  9  source sample address.
REQ-010 SHALL have port src_data  input  16  offset-binary PCM sample, valid one cycle after rd_en/addr_src.
REQ-011 SHALL have port wr_en  output  1  quantized-memory write enable.
REQ-012 SHALL have port addr_dst  output  9  quantized-memory write address.
REQ-013 SHALL have port quan_data  output  4  signed two's-complement quantized sample.
REQ-014 SHALL have port sat_cnt  output  9  count of saturated samples in the current or last frame.

Function
REQ-015 SHALL implement FSM states IDLE, READ, DRAIN, DONE; IDLE->READ on start; READ->DRAIN after the read of address N_SAMPLES-1; DRAIN->DONE after the last write; DONE->IDLE unconditionally.
REQ-016 SHALL assert rd_en for exactly N_SAMPLES consecutive cycles, beginning the cycle after start is sampled in IDLE, with addr_src = 0,1,...,N_SAMPLES-1.
REQ-017 SHALL apply a 2-cycle pipeline: a sample read with addr_src=a at cycle t gives wr_en=1, addr_dst=a, quan_data valid at cycle t+2.
REQ-018 SHALL assert wr_en for exactly N_SAMPLES consecutive cycles per frame and never outside a frame.
REQ-019 SHALL pulse intr high for exactly one cycle, the cycle after the last wr_en.
REQ-020 SHALL hold busy high from the first rd_en cycle through the intr cycle inclusive.
REQ-021 SHALL ignore start while busy=1; start coincident with intr is also ignored.
REQ-022 SHALL convert the sample to signed s = {~src_data[15], src_data[14:0]}.
REQ-023 SHALL compute q = s >>> QSHIFT (arithmetic) without overflow of intermediate width.
REQ-024 SHALL saturate q to [-8,+7] and increment sat_cnt by one for each clipped sample.
REQ-025 SHALL clear sat_cnt to 0 on the first rd_en cycle of a frame and hold it after intr until the next frame.
REQ-026 SHALL hold addr_src, addr_dst and quan_data at their last values when the corresponding enable is low.

Reset
REQ-027 SHALL, while rst=1, force state IDLE and busy, intr, rd_en, wr_en, addr_src, addr_dst, quan_data, sat_cnt all to 0.
REQ-028 SHALL, on rst mid-frame, abort immediately, issue no further rd_en/wr_en, and not pulse intr.
REQ-029 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, with macro QUAN_ROUND_EN defined, round to nearest: q = (s + 2^(QSHIFT-1)) >>> QSHIFT computed in 17 bits, then saturate.
REQ-031 SHALL, without QUAN_ROUND_EN, truncate toward minus infinity per REQ-023.

Verification
REQ-032 SHALL check: reset, start pulse, memory of all 0x8000 -> 256 writes of quan_data=0, addresses 0..255, rd_en first at start+1, wr_en first at start+3, intr single pulse at start+259, sat_cnt=0.
REQ-033 SHALL check: src 0xFFFF and 0x0000 (QSHIFT=11) -> quan_data 4'h7 and 4'h8, sat_cnt=2 for a frame with exactly those two clipped samples.
REQ-034 SHALL check: src 0x8400 and 0x8C00 -> 0 and 1 without QUAN_ROUND_EN; 1 and 2 with QUAN_ROUND_EN.
REQ-035 SHALL check: start re-pulsed at cycle 100 of a frame -> ignored, exactly 256 writes, one intr.
REQ-036 SHALL check: rst asserted at cycle 50 of a frame -> all outputs 0 within the reset, no intr; a following start runs a full clean frame.

Source files
------------

// File: rtl/quan_frame_ctrl.sv
// ============================================================================
// Module      : quan_frame_ctrl
// Description : Frame sequencer that reads N_SAMPLES offset-binary PCM words,
//               quantizes each to a saturated 4-bit signed value and writes it
//               out. Define QUAN_ROUND_EN for round-to-nearest quantization.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module quan_frame_ctrl #(
    parameter int N_SAMPLES = 256,
    parameter int QSHIFT    = 11
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        intr,
    output logic        rd_en,
    output logic [8:0]  addr_src,
    input  logic [15:0] src_data,
    output logic        wr_en,
    output logic [8:0]  addr_dst,
    output logic [3:0]  quan_data,
    output logic [8:0]  sat_cnt
);

    localparam logic [8:0] C_LAST = 9'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic               w_start_frame;
    logic               r_p1_valid;
    logic [8:0]         r_p1_addr;
    logic signed [16:0] w_ext;
    logic signed [16:0] w_sum;
    logic signed [16:0] w_q;
    logic [3:0]         w_qsat;
    logic               w_clip;

    assign w_start_frame = (r_state == IDLE) && start;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        rd_en  = 1'b0;
        intr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = READ;
            end
            READ: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (addr_src == C_LAST) w_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (wr_en && (addr_dst == C_LAST)) w_next = DONE;
            end
            DONE: begin
                busy   = 1'b1;
                intr   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Source address parks on the last sample between frames.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            addr_src <= 9'd0;
        end else if (w_start_frame) begin
            addr_src <= 9'd0;
        end else if (rd_en && (addr_src != C_LAST)) begin
            addr_src <= addr_src + 9'd1;
        end
    end

    // Stage 1 lines up the read address with the returning memory data.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_addr  <= 9'd0;
        end else begin
            r_p1_valid <= rd_en;
            if (rd_en) r_p1_addr <= addr_src;
        end
    end

    // Offset-binary to two's complement is a flip of the MSB.
    assign w_ext = {~src_data[15], ~src_data[15], src_data[14:0]};

`ifdef QUAN_ROUND_EN
    localparam logic signed [16:0] C_HALF = 17'sd1 <<< (QSHIFT - 1);
    assign w_sum = w_ext + C_HALF;
`else
    assign w_sum = w_ext;
`endif

    assign w_q = w_sum >>> QSHIFT;

    always_comb begin
        w_qsat = w_q[3:0];
        w_clip = 1'b0;
        if (w_q > 17'sd7) begin
            w_qsat = 4'h7;
            w_clip = 1'b1;
        end else if (w_q < -17'sd8) begin
            w_qsat = 4'h8;
            w_clip = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wr_en     <= 1'b0;
            addr_dst  <= 9'd0;
            quan_data <= 4'd0;
            sat_cnt   <= 9'd0;
        end else begin
            wr_en <= r_p1_valid;
            if (r_p1_valid) begin
                addr_dst  <= r_p1_addr;
                quan_data <= w_qsat;
            end
            if (w_start_frame) begin
                sat_cnt <= 9'd0;
            end else if (r_p1_valid && w_clip) begin
                sat_cnt <= sat_cnt + 9'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_quan_frame_ctrl.sv
// ============================================================================
// Module      : tb_quan_frame_ctrl
// Description : Scoreboard bench for quan_frame_ctrl with a behavioural source
//               memory and an independent quantizer reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quan_frame_ctrl;

    localparam int C_N  = 256;
    localparam int C_QS = 11;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, intr, rd_en, wr_en;
    logic [8:0]  addr_src, addr_dst, sat_cnt;
    logic [15:0] src_data = 16'd0;
    logic [3:0]  quan_data;

    quan_frame_ctrl #(.N_SAMPLES(C_N), .QSHIFT(C_QS)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .intr      (intr),
        .rd_en     (rd_en),
        .addr_src  (addr_src),
        .src_data  (src_data),
        .wr_en     (wr_en),
        .addr_dst  (addr_dst),
        .quan_data (quan_data),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [8:0] addr;
        logic [3:0] q;
    } exp_t;

    logic [15:0] mem [512];
    logic [3:0]  cap [512];
    exp_t        sbq [$];
    int cyc = 0;
    int checks = 0, errors = 0;
    int rd_cnt, wr_cnt, intr_cnt, first_rd, first_wr, intr_cyc, exp_sat, s_cyc;

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (rd_en) src_data <= mem[addr_src];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_q(input logic [15:0] d, output bit clip);
        int s;
        int q;
        s = int'(d) - 32768;
`ifdef QUAN_ROUND_EN
        s = s + (1 << (C_QS - 1));
`endif
        q = s >>> C_QS;
        clip = 1'b0;
        if (q > 7)  begin q = 7;  clip = 1'b1; end
        if (q < -8) begin q = -8; clip = 1'b1; end
        return q[3:0];
    endfunction

    // Monitor: reads push the expected write, writes pop and compare.
    always @(negedge clk_in) begin
        exp_t e;
        bit   c;
        if (rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            e.addr = addr_src;
            e.q    = ref_q(mem[addr_src], c);
            if (c) exp_sat++;
            sbq.push_back(e);
        end
        if (wr_en) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            chk("wr_in_frame", busy, 1);
            if (sbq.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", addr_dst, e.addr);
                chk("wr_data", quan_data, e.q);
            end
            cap[addr_dst] = quan_data;
        end
        if (intr) begin
            intr_cnt++;
            intr_cyc = cyc;
            chk("busy_at_intr", busy, 1);
        end
    end

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; intr_cnt = 0; exp_sat = 0;
        first_rd = -1; first_wr = -1; intr_cyc = -1;
        sbq.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk_in);
        clear_stats();
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_first_rd"}, first_rd, s_cyc + 1);
        chk({tag, "_first_wr"}, first_wr, s_cyc + 3);
        chk({tag, "_intr_cyc"}, intr_cyc, s_cyc + C_N + 3);
        chk({tag, "_intr_cnt"}, intr_cnt, 1);
        chk({tag, "_rd_cnt"}, rd_cnt, C_N);
        chk({tag, "_wr_cnt"}, wr_cnt, C_N);
        chk({tag, "_sb_left"}, sbq.size(), 0);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_addr_src_hold"}, addr_src, C_N - 1);
        chk({tag, "_addr_dst_hold"}, addr_dst, C_N - 1);
        chk({tag, "_sat_cnt"}, sat_cnt, exp_sat);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear_stats();
        for (int i = 0; i < 512; i++) mem[i] = 16'h8000;
        repeat (3) @(negedge clk_in);
        chk("reset_ctrl", {busy, intr, rd_en, wr_en}, 4'b0000);
        chk("reset_addr", {addr_src, addr_dst}, 18'd0);
        chk("reset_data", {quan_data, sat_cnt}, 13'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk_in);

        // Frame of mid-scale samples: all zero output, timing reference.
        pulse_start();
        repeat (270) @(negedge clk_in);
        check_frame("zero");
        chk("zero_sat_const", sat_cnt, 0);

        // Mixed frame: two clipped extremes, two rounding probes.
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom_range(16'h4000, 16'hB000));
        mem[3]  = 16'hFFFF;
        mem[10] = 16'h0000;
        mem[20] = 16'h8400;
        mem[21] = 16'h8C00;
        pulse_start();
        repeat (270) @(negedge clk_in);
        check_frame("mixed");
        chk("clip_hi", cap[3], 4'h7);
        chk("clip_lo", cap[10], 4'h8);
        chk("sat_cnt_two", sat_cnt, 2);
`ifdef QUAN_ROUND_EN
        chk("round_8400", cap[20], 4'h1);
        chk("round_8C00", cap[21], 4'h2);
`else
        chk("trunc_8400", cap[20], 4'h0);
        chk("trunc_8C00", cap[21], 4'h1);
`endif

        // Second start in mid-frame must be ignored.
        pulse_start();
        repeat (98) @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (170) @(negedge clk_in);
        check_frame("restart_ign");
        repeat (20) @(negedge clk_in);
        chk("restart_no_extra_rd", rd_cnt, C_N);
        chk("restart_no_extra_intr", intr_cnt, 1);

        // Reset in mid-frame aborts without intr; next start runs clean.
        pulse_start();
        repeat (48) @(negedge clk_in);
        rst = 1'b1;
        #1;
        chk("abort_ctrl", {busy, intr, rd_en, wr_en}, 4'b0000);
        chk("abort_addr", {addr_src, addr_dst}, 18'd0);
        chk("abort_data", {quan_data, sat_cnt}, 13'd0);
        clear_stats();
        repeat (3) @(negedge clk_in);
        chk("abort_quiet", {rd_cnt[15:0], wr_cnt[15:0], intr_cnt[15:0]}, 48'd0);
        rst = 1'b0;
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk_in);
        start = 1'b0;
        repeat (270) @(negedge clk_in);
        check_frame("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
